// File: rtl/mem_arb.sv
// mem_arb: two-requester memory-bus arbiter.
//   A fetch requester (read only) and an exec requester (read, write, alloc,
//   set zero-array address) share one memory bus. Each transaction takes three
//   cycles: IDLE (grant and latch), ISSUE (bus driven), RESP (ack plus rdata).
//   Simultaneous requests are resolved round-robin.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   f_req/f_addr/f_off              fetch request and fields
//   f_ack/f_rdata                   fetch completion pulse and read data
//   e_req/e_mode/e_addr/e_off/e_wdata  exec request and fields
//   e_ack/e_rdata                   exec completion pulse and result
//   bus_en/bus_mode/bus_addr/bus_off/bus_data  memory-bus command
//   mem_rdata                       registered read data from memory
//   busy                            high whenever not IDLE
module mem_arb #(
  parameter int FETCH_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic [31:0] f_off,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        e_req,
  input  logic [1:0]  e_mode,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_off,
  input  logic [31:0] e_wdata,
  output logic        e_ack,
  output logic [31:0] e_rdata,
  output logic        bus_en,
  output logic [1:0]  bus_mode,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_off,
  output logic [31:0] bus_data,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Resetting "last grant" to the opposite requester makes FETCH_FIRST's
  // choice win the first tie.
  localparam logic LAST_FETCH_RST = (FETCH_FIRST == 0) ? 1'b1 : 1'b0;

  state_t      state_q, state_d;
  logic        last_fetch_q, last_fetch_d;
  logic        win_fetch_q, win_fetch_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] off_q, off_d;
  logic [31:0] data_q, data_d;

  logic any_req;
  logic grant_fetch;

  assign any_req     = f_req | e_req;
  // Fetch wins when alone, or on a tie when exec was granted last.
  assign grant_fetch = f_req & (~e_req | ~last_fetch_q);

  // State register and transaction latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_fetch_q <= LAST_FETCH_RST;
      win_fetch_q  <= 1'b0;
      mode_q       <= 2'b00;
      addr_q       <= 32'd0;
      off_q        <= 32'd0;
      data_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      win_fetch_q  <= win_fetch_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      data_q       <= data_d;
    end
  end

  // Next-state and grant/latch logic
  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    win_fetch_d  = win_fetch_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    off_d        = off_q;
    data_d       = data_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          last_fetch_d = grant_fetch;
          win_fetch_d  = grant_fetch;
          if (grant_fetch) begin
            mode_d = 2'b00;
            addr_d = f_addr;
            off_d  = f_off;
            data_d = 32'd0;
          end else begin
            mode_d = e_mode;
            addr_d = e_addr;
            off_d  = e_off;
            data_d = e_wdata;
          end
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything is zero outside its active cycle.
  always_comb begin
    bus_en   = 1'b0;
    bus_mode = 2'b00;
    bus_addr = 32'd0;
    bus_off  = 32'd0;
    bus_data = 32'd0;
    f_ack    = 1'b0;
    e_ack    = 1'b0;
    f_rdata  = 32'd0;
    e_rdata  = 32'd0;
    busy     = (state_q != IDLE);
    if (state_q == ISSUE) begin
      bus_en   = 1'b1;
      bus_mode = mode_q;
      bus_addr = addr_q;
      bus_off  = off_q;
      bus_data = data_q;
    end
    if (state_q == RESP) begin
      if (win_fetch_q) begin
        f_ack   = 1'b1;
        f_rdata = mem_rdata;
      end else begin
        e_ack = 1'b1;
        // Read (00) and alloc (10) return memory data; write/set-zero return 0.
        if (!mode_q[0]) e_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb with directed scenarios and a
// randomized run checked against a transaction-level arbitration model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0, f_off = '0;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        e_req = 1'b0;
  logic [1:0]  e_mode = '0;
  logic [31:0] e_addr = '0, e_off = '0, e_wdata = '0;
  logic        e_ack;
  logic [31:0] e_rdata;
  logic        bus_en;
  logic [1:0]  bus_mode;
  logic [31:0] bus_addr, bus_off, bus_data;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_arb #(.FETCH_FIRST(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_off(f_off), .f_ack(f_ack), .f_rdata(f_rdata),
    .e_req(e_req), .e_mode(e_mode), .e_addr(e_addr), .e_off(e_off), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_rdata(e_rdata),
    .bus_en(bus_en), .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_off(bus_off),
    .bus_data(bus_data), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: who was granted last. Reset value lets fetch win the first tie.
  bit m_last_fetch = 1'b0;

  function automatic bit model_pick_fetch(bit f, bit e);
    if (f && e) return !m_last_fetch;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    f_req = 1'b1; e_req = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus_en !== 1'b0 || bus_addr !== 0 || bus_mode !== 0) begin errors++;
      $display("FAIL reset_bus got en=%b mode=%h addr=%h exp 0", bus_en, bus_mode, bus_addr); end
    checks++; if (f_ack !== 1'b0 || e_ack !== 1'b0 || f_rdata !== 0 || e_rdata !== 0) begin errors++;
      $display("FAIL reset_ack got f=%b e=%b fr=%h er=%h exp 0", f_ack, e_ack, f_rdata, e_rdata); end
    f_req = 1'b0; e_req = 1'b0;
    reset_n = 1'b1;
    m_last_fetch = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  // Both held from reset: fetch, exec, fetch with acks three cycles apart.
  task automatic test_tie;
    bit exp_f;
    int last_ack;
    f_req = 1'b1; f_addr = 32'hA0; f_off = 32'h1;
    e_req = 1'b1; e_mode = 2'b01; e_addr = 32'hB0; e_off = 32'h2; e_wdata = 32'h55;
    mem_rdata = 32'h0;
    for (int t = 0; t < 3; t++) begin
      exp_f = (t != 1);
      tick(); // ISSUE
      checks++; if (bus_en !== 1'b1 || bus_addr !== (exp_f ? 32'hA0 : 32'hB0)) begin errors++;
        $display("FAIL tie_bus[%0d] got en=%b addr=%h exp en=1 addr=%h", t, bus_en, bus_addr, exp_f ? 32'hA0 : 32'hB0); end
      tick(); // RESP
      checks++; if (f_ack !== exp_f || e_ack !== !exp_f) begin errors++;
        $display("FAIL tie_ack[%0d] got f=%b e=%b exp f=%b e=%b", t, f_ack, e_ack, exp_f, !exp_f); end
      if (t > 0) begin
        checks++; if (cyc - last_ack != 3) begin errors++;
          $display("FAIL tie_spacing[%0d] got=%0d exp=3", t, cyc - last_ack); end
      end
      last_ack = cyc;
      tick(); // IDLE
    end
    m_last_fetch = 1'b1;
    f_req = 1'b0; e_req = 1'b0;
    $display("tie: order fetch,exec,fetch checked");
    tick();
  endtask

  task automatic test_fetch_read;
    f_req = 1'b1; f_addr = 32'h10; f_off = 32'd3;
    tick();
    checks++; if (bus_en !== 1 || bus_mode !== 2'b00 || bus_addr !== 32'h10 || bus_off !== 32'd3 || bus_data !== 0) begin
      errors++; $display("FAIL fetch_bus got en=%b %h/%h/%h/%h exp 1 00/10/3/0", bus_en, bus_mode, bus_addr, bus_off, bus_data); end
    checks++; if (busy !== 1 || f_ack !== 0) begin errors++; $display("FAIL fetch_issue got busy=%b ack=%b exp 1 0", busy, f_ack); end
    mem_rdata = 32'hDEADBEEF;
    tick();
    checks++; if (f_ack !== 1 || f_rdata !== 32'hDEADBEEF || e_ack !== 0 || bus_en !== 0) begin errors++;
      $display("FAIL fetch_resp got ack=%b rdata=%h eack=%b en=%b exp 1 deadbeef 0 0", f_ack, f_rdata, e_ack, bus_en); end
    f_req = 1'b0;
    m_last_fetch = 1'b1;
    tick();
    checks++; if (f_ack !== 0 || f_rdata !== 0 || busy !== 0) begin errors++;
      $display("FAIL fetch_after got ack=%b rdata=%h busy=%b exp 0 0 0", f_ack, f_rdata, busy); end
    $display("fetch_read: addr=10 off=3 rdata=%h", 32'hDEADBEEF);
  endtask

  // Write, alloc and set-zero on the exec port, plus a field change after grant.
  task automatic test_exec_ops;
    logic [1:0]  modes[3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] addrs[3] = '{32'd5, 32'd0, 32'd0};
    logic [31:0] offs[3]  = '{32'd2, 32'd8, 32'd0};
    logic [31:0] wds[3]   = '{32'h1234, 32'h0, 32'h77};
    logic [31:0] exp_rd;
    for (int i = 0; i < 3; i++) begin
      e_req = 1'b1; e_mode = modes[i]; e_addr = addrs[i]; e_off = offs[i]; e_wdata = wds[i];
      tick();
      if (i == 0) begin
        e_addr = 32'h999; // changed after grant; bus must keep latched value
        #1;
      end
      checks++; if (bus_en !== 1 || bus_mode !== modes[i] || bus_addr !== addrs[i] || bus_off !== offs[i] || bus_data !== wds[i]) begin
        errors++; $display("FAIL exec_bus[%0d] got %h/%h/%h/%h exp %h/%h/%h/%h", i, bus_mode, bus_addr, bus_off, bus_data, modes[i], addrs[i], offs[i], wds[i]); end
      mem_rdata = 32'h400;
      tick();
      exp_rd = (modes[i] == 2'b10) ? 32'h400 : 32'h0;
      checks++; if (e_ack !== 1 || f_ack !== 0 || e_rdata !== exp_rd) begin errors++;
        $display("FAIL exec_resp[%0d] got ack=%b rdata=%h exp 1 %h", i, e_ack, e_rdata, exp_rd); end
      e_req = 1'b0;
      tick();
      $display("exec_op: mode=%b rdata_exp=%h", modes[i], exp_rd);
    end
    m_last_fetch = 1'b0;
  endtask

  task automatic test_reset_mid_issue;
    bit seen_ack;
    e_req = 1'b1; e_mode = 2'b01; e_addr = 32'h3; e_off = 32'h4; e_wdata = 32'h9;
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus_en !== 0 || busy !== 0 || e_ack !== 0 || f_ack !== 0) begin errors++;
      $display("FAIL rst_mid got en=%b busy=%b eack=%b fack=%b exp 0", bus_en, busy, e_ack, f_ack); end
    e_req = 1'b0;
    seen_ack = 1'b0;
    repeat (3) begin tick(); if (e_ack || f_ack) seen_ack = 1'b1; end
    checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack got=1 exp=0"); end
    reset_n = 1'b1;
    m_last_fetch = 1'b0;
    e_req = 1'b1; e_mode = 2'b00; e_addr = 32'h21; e_off = 32'h0;
    tick();
    checks++; if (bus_en !== 1 || bus_addr !== 32'h21) begin errors++;
      $display("FAIL rst_recover_bus got en=%b addr=%h exp 1 21", bus_en, bus_addr); end
    mem_rdata = 32'hCAFE;
    tick();
    checks++; if (e_ack !== 1 || e_rdata !== 32'hCAFE) begin errors++;
      $display("FAIL rst_recover_ack got ack=%b rdata=%h exp 1 cafe", e_ack, e_rdata); end
    e_req = 1'b0;
    m_last_fetch = 1'b0;
    tick();
    $display("reset_mid_issue: abandoned and recovered");
  endtask

  // Random traffic; loser keeps its request, winner's ports are scrambled after grant.
  task automatic test_random;
    bit fp = 0, ep = 0, win_f;
    logic [31:0] fa, fo, ea, eo, ew, mr, exp_rd;
    logic [1:0]  em;
    logic [1:0]  x_mode; logic [31:0] x_addr, x_off, x_data;
    for (int n = 0; n < 60; n++) begin
      if (!fp && $urandom_range(1, 0)) begin fp = 1; fa = $urandom; fo = $urandom; end
      if (!ep && $urandom_range(1, 0)) begin ep = 1; em = 2'($urandom); ea = $urandom; eo = $urandom; ew = $urandom; end
      if (!fp && !ep) begin ep = 1; em = 2'($urandom); ea = $urandom; eo = $urandom; ew = $urandom; end
      f_req = fp; f_addr = fa; f_off = fo;
      e_req = ep; e_mode = em; e_addr = ea; e_off = eo; e_wdata = ew;
      win_f = model_pick_fetch(fp, ep);
      m_last_fetch = win_f;
      x_mode = win_f ? 2'b00 : em; x_addr = win_f ? fa : ea;
      x_off = win_f ? fo : eo;     x_data = win_f ? 32'h0 : ew;
      tick(); // ISSUE
      if (win_f) begin f_addr = $urandom; f_off = $urandom; end
      else begin e_mode = 2'($urandom); e_addr = $urandom; e_off = $urandom; e_wdata = $urandom; end
      #1;
      checks++; if (bus_en !== 1 || bus_mode !== x_mode || bus_addr !== x_addr || bus_off !== x_off || bus_data !== x_data) begin
        errors++; $display("FAIL rnd_bus[%0d] got %b %h/%h/%h/%h exp 1 %h/%h/%h/%h", n, bus_en, bus_mode, bus_addr, bus_off, bus_data, x_mode, x_addr, x_off, x_data); end
      mr = $urandom; mem_rdata = mr;
      tick(); // RESP
      exp_rd = (x_mode == 2'b01 || x_mode == 2'b11) ? 32'h0 : mr;
      checks++; if (f_ack !== win_f || e_ack !== !win_f || (win_f ? f_rdata : e_rdata) !== exp_rd
                    || (win_f ? e_rdata : f_rdata) !== 0 || bus_en !== 0 || busy !== 1) begin
        errors++; $display("FAIL rnd_resp[%0d] got f=%b e=%b fr=%h er=%h exp f=%b rd=%h", n, f_ack, e_ack, f_rdata, e_rdata, win_f, exp_rd); end
      if (win_f) fp = 0; else ep = 0;
      tick(); // IDLE
      checks++; if (busy !== 0 || f_ack !== 0 || e_ack !== 0) begin errors++;
        $display("FAIL rnd_idle[%0d] got busy=%b f=%b e=%b exp 0", n, busy, f_ack, e_ack); end
      $display("rnd[%0d]: f=%b e=%b winner=%s mode=%b", n, f_req, e_req, win_f ? "fetch" : "exec", x_mode);
    end
    f_req = 0; e_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_fetch_read();
    test_exec_ops();
    test_reset_mid_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
